// File: rtl/dct_pkg.sv
// Shared constants and operand types for the row-DCT front stage.
package dct_pkg;
   localparam int PIX_W       = 8;
   localparam int DA_W        = 12;
   localparam int LEVEL_SHIFT = 128;
   localparam int ROW_LEN     = 8;

   typedef logic signed [DA_W-1:0] da_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ISSUE,
      ST_GAP
   } issue_state_e;
endpackage

// File: rtl/dct_row_bank.sv
// One row of level-shifted samples with a full flag; set_full wins over clr,
// though the issue logic never targets the bank being written.
module dct_row_bank
   import dct_pkg::*;
#(
   parameter int DW = 9
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic                             wr_en_i,
   input  logic [$clog2(ROW_LEN)-1:0]       wr_addr_i,
   input  logic [DW-1:0]                    wr_data_i,
   input  logic                             set_full_i,
   input  logic                             clr_i,
   output logic                             full_o,
   output logic [ROW_LEN-1:0][DW-1:0]       data_o
);

   logic [ROW_LEN-1:0][DW-1:0] data_q;
   logic                       full_q, full_d;

   always_comb begin
      full_d = full_q;
      if (set_full_i)
         full_d = 1'b1;
      else if (clr_i)
         full_d = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         if (wr_en_i)
            data_q[wr_addr_i] <= wr_data_i;
         full_q <= full_d;
      end
   end

   assign full_o = full_q;
   assign data_o = data_q;
endmodule

// File: rtl/dct_row_butterfly.sv
// Row-DCT front stage: level shift, two-row ping-pong capture, butterfly fold
// and paced issue of X/Y operands to the DA coefficient units.
//
//   state    | meaning
//   ST_IDLE  | waiting for the read bank to fill
//   ST_ISSUE | DA_start high, X/Y just loaded from the read bank
//   ST_GAP   | holding off until ISSUE_GAP cycles have elapsed
module dct_row_butterfly
   import dct_pkg::*;
#(
   parameter int ISSUE_GAP = 6,
   parameter int PIX_W     = 8
) (
   input  logic              sys_clk,
   input  logic              sys_rst,
   input  logic [PIX_W-1:0]  pix_in,
   input  logic              pix_valid,
   output logic              pix_ready,
   output da_t               X0,
   output da_t               X1,
   output da_t               X2,
   output da_t               X3,
   output da_t               Y0,
   output da_t               Y1,
   output da_t               Y2,
   output da_t               Y3,
   output logic              DA_start,
   output logic [2:0]        row_idx
);

   localparam int SW = PIX_W + 1;
   localparam int AW = $clog2(ROW_LEN);
   localparam int GW = $clog2(ISSUE_GAP + 1);

   logic                                  wr_bank_q, wr_bank_d;
   logic [AW-1:0]                         wr_ptr_q, wr_ptr_d;
   logic                                  rd_bank_q, rd_bank_d;
   issue_state_e                          state_q, state_d;
   logic [GW-1:0]                         gap_q, gap_d;
   logic [2:0]                            row_idx_q, row_idx_d;
   logic [3:0][DA_W-1:0]                  x_q, x_d, y_q, y_d;
   logic [3:0][DA_W-1:0]                  x_bf, y_bf;

   logic [1:0]                            bank_full;
   logic [1:0][ROW_LEN-1:0][SW-1:0]       bank_data;
   logic [ROW_LEN-1:0][SW-1:0]            rd_data;
   logic [SW-1:0]                         pix_shift;
   logic                                  accept, row_done, rd_full, issue_go;

   assign pix_ready = ~(bank_full[0] & bank_full[1]);
   assign accept    = pix_valid & pix_ready;
   assign row_done  = accept && (wr_ptr_q == AW'(ROW_LEN - 1));
   assign pix_shift = {1'b0, pix_in} - SW'(LEVEL_SHIFT);
   assign rd_full   = bank_full[rd_bank_q];
   assign rd_data   = bank_data[rd_bank_q];

   for (genvar b = 0; b < 2; b++) begin : g_bank
      dct_row_bank #(.DW(SW)) u_bank (
         .clk_i      (sys_clk),
         .rst_i      (sys_rst),
         .wr_en_i    (accept && (wr_bank_q == 1'(b))),
         .wr_addr_i  (wr_ptr_q),
         .wr_data_i  (pix_shift),
         .set_full_i (row_done && (wr_bank_q == 1'(b))),
         .clr_i      (issue_go && (rd_bank_q == 1'(b))),
         .full_o     (bank_full[b]),
         .data_o     (bank_data[b])
      );
   end

   // Sum/difference of two 9-bit samples needs 10 bits; sign-extend to DA_W.
   for (genvar k = 0; k < 4; k++) begin : g_bfly
      logic [SW-1:0] s_lo, s_hi;
      logic [SW:0]   sum_w, dif_w;
      assign s_lo     = rd_data[k];
      assign s_hi     = rd_data[ROW_LEN-1-k];
      assign sum_w    = {s_lo[SW-1], s_lo} + {s_hi[SW-1], s_hi};
      assign dif_w    = {s_lo[SW-1], s_lo} - {s_hi[SW-1], s_hi};
      assign x_bf[k]  = {{(DA_W-SW-1){sum_w[SW]}}, sum_w};
      assign y_bf[k]  = {{(DA_W-SW-1){dif_w[SW]}}, dif_w};
   end

   always_comb begin
      wr_ptr_d  = wr_ptr_q;
      wr_bank_d = wr_bank_q;
      if (accept)
         wr_ptr_d = wr_ptr_q + AW'(1);
      if (row_done)
         wr_bank_d = ~wr_bank_q;
   end

   // A backlogged row issues on the edge the gap expires, so pulses
   // under backlog are exactly ISSUE_GAP cycles apart.
   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      rd_bank_d = rd_bank_q;
      row_idx_d = row_idx_q;
      x_d       = x_q;
      y_d       = y_q;
      issue_go  = 1'b0;
      case (state_q)
         ST_IDLE: issue_go = rd_full;
         ST_ISSUE, ST_GAP: begin
            if (gap_q == '0) begin
               issue_go = rd_full;
               state_d  = ST_IDLE;
            end else begin
               gap_d   = gap_q - GW'(1);
               state_d = ST_GAP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
      if (issue_go) begin
         state_d   = ST_ISSUE;
         gap_d     = GW'(ISSUE_GAP - 1);
         rd_bank_d = ~rd_bank_q;
         row_idx_d = row_idx_q + 3'd1;
         x_d       = x_bf;
         y_d       = y_bf;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         wr_bank_q <= 1'b0;
         wr_ptr_q  <= '0;
         rd_bank_q <= 1'b0;
         state_q   <= ST_IDLE;
         gap_q     <= '0;
         row_idx_q <= 3'd7;
         x_q       <= '0;
         y_q       <= '0;
      end else begin
         wr_bank_q <= wr_bank_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_bank_q <= rd_bank_d;
         state_q   <= state_d;
         gap_q     <= gap_d;
         row_idx_q <= row_idx_d;
         x_q       <= x_d;
         y_q       <= y_d;
      end
   end

   assign DA_start = (state_q == ST_ISSUE);
   assign row_idx  = row_idx_q;
   assign X0 = x_q[0];
   assign X1 = x_q[1];
   assign X2 = x_q[2];
   assign X3 = x_q[3];
   assign Y0 = y_q[0];
   assign Y1 = y_q[1];
   assign Y2 = y_q[2];
   assign Y3 = y_q[3];
endmodule

// File: tb/tb_dct_row_butterfly.sv
// Bench for dct_row_butterfly: default-gap instance for function/latency,
// ISSUE_GAP=12 instance for back-pressure and issue spacing.
module tb_dct_row_butterfly;
   import dct_pkg::*;

   typedef struct packed {
      logic [3:0][11:0] x;
      logic [3:0][11:0] y;
      logic [2:0]       ri;
      int               cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   logic [7:0] pix0, pix1;
   logic pv0, pv1, rdy0, rdy1, ds0, ds1;
   logic [2:0] ri0o, ri1o;
   da_t a_x0, a_x1, a_x2, a_x3, a_y0, a_y1, a_y2, a_y3;
   da_t b_x0, b_x1, b_x2, b_x3, b_y0, b_y1, b_y2, b_y3;
   logic [3:0][11:0] xs0, ys0, xs1, ys1;

   always #5 clk = ~clk;

   dct_row_butterfly #(.ISSUE_GAP(6), .PIX_W(8)) dut0 (
      .sys_clk(clk), .sys_rst(rst), .pix_in(pix0), .pix_valid(pv0), .pix_ready(rdy0),
      .X0(a_x0), .X1(a_x1), .X2(a_x2), .X3(a_x3),
      .Y0(a_y0), .Y1(a_y1), .Y2(a_y2), .Y3(a_y3),
      .DA_start(ds0), .row_idx(ri0o)
   );

   dct_row_butterfly #(.ISSUE_GAP(12), .PIX_W(8)) dut1 (
      .sys_clk(clk), .sys_rst(rst), .pix_in(pix1), .pix_valid(pv1), .pix_ready(rdy1),
      .X0(b_x0), .X1(b_x1), .X2(b_x2), .X3(b_x3),
      .Y0(b_y0), .Y1(b_y1), .Y2(b_y2), .Y3(b_y3),
      .DA_start(ds1), .row_idx(ri1o)
   );

   assign xs0 = {a_x3, a_x2, a_x1, a_x0};
   assign ys0 = {a_y3, a_y2, a_y1, a_y0};
   assign xs1 = {b_x3, b_x2, b_x1, b_x0};
   assign ys1 = {b_y3, b_y2, b_y1, b_y0};

   exp_t q0[$];
   exp_t q1[$];
   int   n_assert = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   buf0[8];
   int   buf1[8];
   int   cnt0, cnt1, rix0, rix1;
   int   last_issue1, issues1;
   bit   saw_stall;
   logic [3:0][11:0] held_x, held_y;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t mk(input int p[8], input int ri, input int c);
      exp_t e;
      int s[8];
      for (int i = 0; i < 8; i++) s[i] = p[i] - 128;
      for (int k = 0; k < 4; k++) begin
         e.x[k] = 12'(s[k] + s[7-k]);
         e.y[k] = 12'(s[k] - s[7-k]);
      end
      e.ri  = 3'(ri);
      e.cyc = c;
      return e;
   endfunction

   task automatic tick(output bit acc1);
      bit a0, a1;
      exp_t e;
      a0 = pv0 && rdy0;
      a1 = pv1 && rdy1;
      if (pv0) check("ready0_high", rdy0, 1);
      if (pv1 && !rdy1) saw_stall = 1;
      @(posedge clk);
      #1;
      cyc++;
      acc1 = a1;
      if (a0) begin
         buf0[cnt0] = pix0;
         cnt0++;
         if (cnt0 == 8) begin
            q0.push_back(mk(buf0, rix0, cyc));
            rix0 = (rix0 + 1) % 8;
            cnt0 = 0;
         end
      end
      if (a1) begin
         buf1[cnt1] = pix1;
         cnt1++;
         if (cnt1 == 8) begin
            q1.push_back(mk(buf1, rix1, cyc));
            rix1 = (rix1 + 1) % 8;
            cnt1 = 0;
         end
      end
      if (ds0) begin
         check("issue0_expected", q0.size() != 0, 1);
         if (q0.size() != 0) begin
            e = q0.pop_front();
            check("latency0", cyc - e.cyc, 1);
            check("x0", xs0, e.x);
            check("y0", ys0, e.y);
            check("row_idx0", ri0o, e.ri);
            held_x = e.x;
            held_y = e.y;
         end
      end else begin
         check("hold_x0", xs0, held_x);
         check("hold_y0", ys0, held_y);
      end
      if (ds1) begin
         check("issue1_expected", q1.size() != 0, 1);
         if (last_issue1 >= 0) check("spacing1", cyc - last_issue1, 12);
         last_issue1 = cyc;
         issues1++;
         if (q1.size() != 0) begin
            e = q1.pop_front();
            check("x1", xs1, e.x);
            check("y1", ys1, e.y);
            check("row_idx1", ri1o, e.ri);
         end
      end
   endtask

   task automatic do_reset();
      bit d;
      pv0 = 0;
      pv1 = 0;
      rst = 1;
      #2;
      check("rst_da_start", ds0, 0);
      check("rst_x", xs0, 0);
      check("rst_y", ys0, 0);
      check("rst_row_idx", ri0o, 7);
      check("rst_ready0", rdy0, 1);
      check("rst_ready1", rdy1, 1);
      @(posedge clk);
      #1;
      cyc++;
      rst = 0;
      cnt0 = 0; cnt1 = 0; rix0 = 0; rix1 = 0;
      q0.delete();
      q1.delete();
      held_x = '0; held_y = '0;
      last_issue1 = -1;
      issues1 = 0;
      saw_stall = 0;
      d = 0;
   endtask

   task automatic idle(input int n);
      bit d;
      pv0 = 0;
      pv1 = 0;
      repeat (n) tick(d);
   endtask

   task automatic send0(input int p[8]);
      bit d;
      for (int i = 0; i < 8; i++) begin
         pix0 = 8'(p[i]);
         pv0 = 1;
         tick(d);
      end
   endtask

   task automatic send1(input int p[8]);
      bit acc;
      int n;
      for (int i = 0; i < 8; i++) begin
         pix1 = 8'(p[i]);
         pv1 = 1;
         n = 0;
         acc = 0;
         while (!acc && n < 100) begin
            tick(acc);
            n++;
         end
         check("accept1", acc, 1);
      end
   endtask

   initial begin
      int row[8];
      int n;
      bit d;
      rst = 1; pv0 = 0; pv1 = 0; pix0 = 0; pix1 = 0;
      held_x = '0; held_y = '0;
      do_reset();

      // all-128 rows, continuous: row_idx 0..7 then wraps to 0
      for (int i = 0; i < 8; i++) row[i] = 128;
      repeat (9) send0(row);
      idle(4);

      for (int i = 0; i < 8; i++) row[i] = i;
      send0(row);
      for (int i = 0; i < 8; i++) row[i] = (i % 2 == 0) ? 255 : 0;
      send0(row);
      for (int i = 0; i < 8; i++) row[i] = 255;
      send0(row);
      for (int i = 0; i < 8; i++) row[i] = 0;
      send0(row);
      idle(4);

      // reset mid-row: partial row must never issue
      for (int i = 0; i < 5; i++) begin
         pix0 = 8'(40 + i);
         pv0 = 1;
         tick(d);
      end
      do_reset();
      idle(12);
      for (int i = 0; i < 8; i++) row[i] = 128;
      send0(row);
      idle(4);

      // gap 12 with continuous input: back-pressure and exact spacing
      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < 8; i++) row[i] = int'($urandom_range(255));
         send1(row);
      end
      pv1 = 0;
      n = 0;
      while (q1.size() != 0 && n < 300) begin
         tick(d);
         n++;
      end
      idle(14);
      check("drain1", q1.size(), 0);
      check("stall_seen1", saw_stall, 1);
      check("issues1", issues1, 6);
      check("drain0", q0.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end
endmodule
